// File: rtl/ysyx_24090018_ifu.sv
// Instruction fetch unit: one fetch in flight, flush-safe, {pc, inst, fault} to decode.
// Optional counters enabled by defining YSYX_24090018_IFU_PERF_EN.
module ysyx_24090018_ifu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic                  pc_valid_i,
  output logic                  pc_ready_o,
  input  logic                  flush_i,
  output logic                  imem_req_valid_o,
  input  logic                  imem_req_ready_i,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data_i,
  input  logic                  imem_rsp_err_i,
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] inst_pc_o,
  output logic                  inst_fault_o
`ifdef YSYX_24090018_IFU_PERF_EN
  ,
  output logic [31:0]           perf_fetch_cnt_o,
  output logic [31:0]           perf_stall_cnt_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_e;

  state_e                state_q, state_d;
  logic                  drop_q, drop_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic                  fault_q, fault_d;

  assign pc_ready_o       = (state_q == S_IDLE) && !flush_i;
  assign imem_req_valid_o = (state_q == S_REQ);
  assign inst_valid_o     = (state_q == S_HOLD);
  assign imem_addr_o      = addr_q;
  assign inst_pc_o        = addr_q;
  assign inst_o           = inst_q;
  assign inst_fault_o     = fault_q;

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    addr_d  = addr_q;
    inst_d  = inst_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: begin
        if (pc_valid_i && pc_ready_o) begin
          addr_d = pc_i;
          if (pc_i[1:0] == 2'b00) begin
            state_d = S_REQ;
          end else begin
            // Misaligned: report the fault directly without touching memory
            state_d = S_HOLD;
            inst_d  = '0;
            fault_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (imem_req_ready_i) begin
          state_d = S_WAIT;
          drop_d  = flush_i;
        end else if (flush_i) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid_i) begin
          if (drop_q || flush_i) begin
            state_d = S_IDLE;
            drop_d  = 1'b0;
          end else begin
            state_d = S_HOLD;
            inst_d  = imem_rsp_data_i;
            fault_d = imem_rsp_err_i;
          end
        end else if (flush_i) begin
          // The granted read must still drain; remember to discard it
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (flush_i || inst_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      drop_q  <= 1'b0;
      addr_q  <= '0;
      inst_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      fault_q <= fault_d;
    end
  end

`ifdef YSYX_24090018_IFU_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (inst_valid_o && inst_ready_i && !flush_i) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (state_q == S_REQ || state_q == S_WAIT)    stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt_o = fetch_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_24090018_ifu.sv
// Directed plus randomized bench for ysyx_24090018_ifu; expected results derive from
// per-transaction rules (aligned -> memory data/err, misaligned -> fault with zero word).
module tb_ysyx_24090018_ifu;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        pc_valid_i, pc_ready_o, flush_i;
  logic        imem_req_valid_o, imem_req_ready_i;
  logic [31:0] imem_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        imem_rsp_err_i;
  logic        inst_valid_o, inst_ready_i;
  logic [31:0] inst_o, inst_pc_o;
  logic        inst_fault_o;
`ifdef YSYX_24090018_IFU_PERF_EN
  logic [31:0] perf_fetch_cnt_o, perf_stall_cnt_o;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ysyx_24090018_ifu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .pc_i(pc_i), .pc_valid_i(pc_valid_i), .pc_ready_o(pc_ready_o), .flush_i(flush_i),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
    .imem_addr_o(imem_addr_o), .imem_rsp_valid_i(imem_rsp_valid_i),
    .imem_rsp_data_i(imem_rsp_data_i), .imem_rsp_err_i(imem_rsp_err_i),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i), .inst_o(inst_o),
    .inst_pc_o(inst_pc_o), .inst_fault_o(inst_fault_o)
`ifdef YSYX_24090018_IFU_PERF_EN
    , .perf_fetch_cnt_o(perf_fetch_cnt_o), .perf_stall_cnt_o(perf_stall_cnt_o)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transaction. gd/rd/hd are grant, response and decode-accept delays.
  task automatic fetch(input logic [31:0] pc, input logic [31:0] data, input int gd,
                       input int rd, input int hd, input logic err, input logic fl_hold);
    logic        mis;
    logic [31:0] exp_inst;
    logic        exp_fault;
`ifdef YSYX_24090018_IFU_PERF_EN
    logic [31:0] s0, f0;
    s0 = perf_stall_cnt_o;
    f0 = perf_fetch_cnt_o;
`endif
    mis       = (pc[1:0] != 2'b00);
    exp_inst  = mis ? 32'h0 : data;
    exp_fault = mis | err;
    pc_i = pc; pc_valid_i = 1'b1;
    #1 chk("pc_ready_idle", pc_ready_o, 1'b1);
    @(negedge clk);
    pc_valid_i = 1'b0; pc_i = $urandom;
    if (!mis) begin
      chk("req_valid", imem_req_valid_o, 1'b1);
      chk("req_addr", imem_addr_o, pc);
      for (int i = 0; i < gd; i++) begin
        @(negedge clk);
        chk("req_valid_stall", imem_req_valid_o, 1'b1);
        chk("req_addr_stall", imem_addr_o, pc);
        chk("pc_ready_busy", pc_ready_o, 1'b0);
      end
      imem_req_ready_i = 1'b1;
      @(negedge clk);
      imem_req_ready_i = 1'b0;
      chk("req_valid_granted", imem_req_valid_o, 1'b0);
      for (int i = 0; i < rd; i++) begin
        @(negedge clk);
        chk("inst_valid_wait", inst_valid_o, 1'b0);
      end
      imem_rsp_valid_i = 1'b1; imem_rsp_data_i = data; imem_rsp_err_i = err;
      @(negedge clk);
      imem_rsp_valid_i = 1'b0; imem_rsp_data_i = $urandom; imem_rsp_err_i = 1'b0;
    end else begin
      chk("mis_no_req", imem_req_valid_o, 1'b0);
    end
    chk("inst_valid", inst_valid_o, 1'b1);
    chk("inst", inst_o, exp_inst);
    chk("inst_pc", inst_pc_o, pc);
    chk("inst_fault", inst_fault_o, exp_fault);
    for (int i = 0; i < hd; i++) begin
      @(negedge clk);
      chk("hold_valid", inst_valid_o, 1'b1);
      chk("hold_inst", inst_o, exp_inst);
      chk("hold_pc", inst_pc_o, pc);
      chk("hold_fault", inst_fault_o, exp_fault);
      chk("hold_pc_ready", pc_ready_o, 1'b0);
    end
    inst_ready_i = 1'b1; flush_i = fl_hold;
    @(negedge clk);
    inst_ready_i = 1'b0; flush_i = 1'b0;
    #1;
    chk("done_valid", inst_valid_o, 1'b0);
    chk("done_pc_ready", pc_ready_o, 1'b1);
`ifdef YSYX_24090018_IFU_PERF_EN
    chk("perf_fetch", perf_fetch_cnt_o - f0, fl_hold ? 32'd0 : 32'd1);
    chk("perf_stall", perf_stall_cnt_o - s0, mis ? 32'd0 : 32'(gd + rd + 2));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; pc_i = '0; pc_valid_i = 1'b0; flush_i = 1'b0;
    imem_req_ready_i = 1'b0; imem_rsp_valid_i = 1'b0; imem_rsp_data_i = '0;
    imem_rsp_err_i = 1'b0; inst_ready_i = 1'b0;
    @(negedge clk);
    chk("rst_req_valid", imem_req_valid_o, 1'b0);
    chk("rst_inst_valid", inst_valid_o, 1'b0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_inst_pc", inst_pc_o, 32'h0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_fault", inst_fault_o, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Zero-wait basic fetch, then backpressure, misalignment, bus error, HOLD flush
    fetch(32'h8000_0000, 32'h0010_0093, 0, 0, 0, 1'b0, 1'b0);
    fetch(32'h8000_0010, 32'h1234_5678, 3, 1, 4, 1'b0, 1'b0);
    fetch(32'h8000_0002, 32'hFFFF_FFFF, 0, 0, 0, 1'b0, 1'b0);
    fetch(32'h8000_0020, 32'hCAFE_F00D, 0, 0, 1, 1'b1, 1'b0);
    fetch(32'h8000_0030, 32'h0000_0013, 1, 0, 2, 1'b0, 1'b1);

    flush_i = 1'b1;
    #1 chk("idle_flush_pc_ready", pc_ready_o, 1'b0);
    flush_i = 1'b0;

    // Flush one cycle after grant; stale response must vanish
    pc_i = 32'h8000_0000; pc_valid_i = 1'b1;
    @(negedge clk);
    pc_valid_i = 1'b0; imem_req_ready_i = 1'b1;
    @(negedge clk);
    imem_req_ready_i = 1'b0; flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("wflush_valid0", inst_valid_o, 1'b0);
    @(negedge clk);
    chk("wflush_valid1", inst_valid_o, 1'b0);
    imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rsp_valid_i = 1'b0;
    chk("wflush_valid2", inst_valid_o, 1'b0);
    #1 chk("wflush_idle", pc_ready_o, 1'b1);
    fetch(32'h8000_0004, 32'h0020_0113, 0, 1, 0, 1'b0, 1'b0);

    // Flush in REQ without grant withdraws the request
    pc_i = 32'h8000_0008; pc_valid_i = 1'b1;
    @(negedge clk);
    pc_valid_i = 1'b0; flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("rflush_req", imem_req_valid_o, 1'b0);
    #1 chk("rflush_idle", pc_ready_o, 1'b1);

    // Flush together with grant: the response is owed but discarded
    pc_i = 32'h8000_000C; pc_valid_i = 1'b1;
    @(negedge clk);
    pc_valid_i = 1'b0; flush_i = 1'b1; imem_req_ready_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0; imem_req_ready_i = 1'b0;
    chk("gflush_req", imem_req_valid_o, 1'b0);
    chk("gflush_pc_ready", pc_ready_o, 1'b0);
    imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'h1111_2222;
    @(negedge clk);
    imem_rsp_valid_i = 1'b0;
    chk("gflush_valid", inst_valid_o, 1'b0);
    #1 chk("gflush_idle", pc_ready_o, 1'b1);

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      logic [31:0] rpc;
      rpc = {$urandom} & 32'hFFFF_FFFC;
      if ($urandom_range(0, 5) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      fetch(rpc, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 7) == 0));
    end

    // Asynchronous reset while waiting for a response
    fetch(32'h8000_0100, 32'hA5A5_5A5A, 0, 0, 0, 1'b0, 1'b0);
    pc_i = 32'h8000_0040; pc_valid_i = 1'b1;
    @(negedge clk);
    pc_valid_i = 1'b0; imem_req_ready_i = 1'b1;
    @(negedge clk);
    imem_req_ready_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_req_valid", imem_req_valid_o, 1'b0);
    chk("arst_inst_valid", inst_valid_o, 1'b0);
    chk("arst_inst", inst_o, 32'h0);
    chk("arst_inst_pc", inst_pc_o, 32'h0);
    chk("arst_addr", imem_addr_o, 32'h0);
    chk("arst_fault", inst_fault_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'hBAD0_BAD0;
    @(negedge clk);
    imem_rsp_valid_i = 1'b0;
    chk("stray_rsp_valid", inst_valid_o, 1'b0);
    #1 chk("stray_rsp_idle", pc_ready_o, 1'b1);
`ifdef YSYX_24090018_IFU_PERF_EN
    chk("arst_perf_fetch", perf_fetch_cnt_o, 32'h0);
    chk("arst_perf_stall", perf_stall_cnt_o, 32'h0);
`endif
    fetch(32'h8000_0044, 32'h0030_0193, 0, 0, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
